// File: rtl/cbd_sampler_if.sv
// Coefficient sampler bus: PRF block capture on one side, coefficient stream on the other.
interface cbd_sampler_if #(
  parameter int unsigned Z_W    = 1536,
  parameter int unsigned COEF_W = 12
);
  logic [0:Z_W-1]    Z;
  logic              start;
  logic [1:0]        n_num;
  logic [COEF_W-1:0] coef;
  logic [7:0]        coef_idx;
  logic              coef_valid;
  logic              coef_ready;
  logic              busy;
  logic              done;

  // Producer of PRF blocks and consumer of coefficients.
  modport master (
    output Z, start, n_num, coef_ready,
    input  coef, coef_idx, coef_valid, busy, done
  );

  // The sampler itself.
  modport slave (
    input  Z, start, n_num, coef_ready,
    output coef, coef_idx, coef_valid, busy, done
  );
endinterface

// File: rtl/cbd_sampler.sv
// Kyber CBD_eta sampler: turns a captured PRF block into 256 coefficients mod Q,
// streamed one per cycle over a valid/ready handshake.
module cbd_sampler #(
  parameter int unsigned Q      = 3329,
  parameter int unsigned N_COEF = 256,
  parameter int unsigned Z_W    = 1536,
  parameter int unsigned COEF_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  cbd_sampler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic [0:Z_W-1]    sr_q, sr_d;
  logic [0:Z_W-1]    sr_shift;
  logic              eta3_q, eta3_d;
  logic [COEF_W-1:0] coef_q, coef_d;
  logic [7:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              accept;

  // a counts the first eta bits, b the next eta; result folded into [0, Q-1].
  function automatic logic [COEF_W-1:0] cbd(input logic [0:5] w, input logic eta3);
    logic [1:0] a;
    logic [1:0] b;
    a = {1'b0, w[0]} + {1'b0, w[1]} + {1'b0, eta3 & w[2]};
    b = eta3 ? ({1'b0, w[3]} + {1'b0, w[4]} + {1'b0, w[5]})
             : ({1'b0, w[2]} + {1'b0, w[3]});
    if (a >= b) return COEF_W'(a - b);
    else        return COEF_W'(Q - 32'(b - a));
  endfunction

  assign accept   = valid_q & bus.coef_ready;
  assign sr_shift = eta3_q ? (sr_q << 6) : (sr_q << 4);

  // Next-state: capture in idle, prime then advance on each handshake in emit.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    eta3_d  = eta3_q;
    coef_d  = coef_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (bus.start && (bus.n_num == 2'd1 || bus.n_num == 2'd2)) begin
          sr_d    = bus.Z;
          eta3_d  = (bus.n_num == 2'd1);
          idx_d   = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (!valid_q) begin
          // First cycle after capture: present coefficient 0.
          valid_d = 1'b1;
          coef_d  = cbd(sr_q[0:5], eta3_q);
        end else if (accept) begin
          if (idx_q == 8'(N_COEF - 1)) begin
            valid_d = 1'b0;
            state_d = StDone;
          end else begin
            sr_d   = sr_shift;
            idx_d  = idx_q + 8'd1;
            coef_d = cbd(sr_shift[0:5], eta3_q);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      eta3_q  <= 1'b0;
      coef_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      eta3_q  <= eta3_d;
      coef_q  <= coef_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign bus.coef       = coef_q;
  assign bus.coef_idx   = idx_q;
  assign bus.coef_valid = valid_q;
  assign bus.busy       = (state_q == StEmit);
  assign bus.done       = (state_q == StDone);

endmodule

// File: tb/tb_cbd_sampler.sv
// Self-checking bench for cbd_sampler using a queue of expected coefficients.
module tb_cbd_sampler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cbd_sampler_if bus ();

  cbd_sampler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] coef;
    logic [7:0]  idx;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference CBD from the raw bit stream, independent of any shifting.
  function automatic logic [11:0] model_coef(input logic [0:1535] z, input int eta,
                                             input int i);
    int base;
    int a;
    int b;
    base = 2 * eta * i;
    a = 0;
    b = 0;
    for (int j = 0; j < eta; j++) begin
      a += int'(z[base + j]);
      b += int'(z[base + eta + j]);
    end
    if (a >= b) return 12'(a - b);
    else        return 12'(3329 - (b - a));
  endfunction

  function automatic logic [0:1535] rand_z();
    logic [0:1535] z;
    for (int k = 0; k < 48; k++) z[k*32 +: 32] = $urandom;
    return z;
  endfunction

  task automatic kick(input logic [0:1535] z, input logic [1:0] n);
    @(posedge clk);
    #1;
    bus.Z     = z;
    bus.n_num = n;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if (bus.coef_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.coef !== 12'd0 || bus.coef_idx !== 8'd0) begin
      n_err++;
      $display("FAIL reset: valid=%b busy=%b done=%b coef=%0d idx=%0d, required all 0",
               bus.coef_valid, bus.busy, bus.done, bus.coef, bus.coef_idx);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Full 256-coefficient run with optional stall, mid-stream start and start-in-done.
  task automatic test_stream(input string name, input logic [0:1535] z, input logic [1:0] n,
                             input int exp0, input int stall_idx, input int poke_idx,
                             input bit poke_done);
    int eta;
    int cycles;
    int stall;
    bit rdy;
    eta = (n == 2'd1) ? 3 : 2;
    bus.coef_ready = 1'b1;
    kick(z, n);
    for (int i = 0; i < 256; i++) sb.push_back('{model_coef(z, eta, i), 8'(i)});
    @(negedge clk);
    n_vec++;
    if (bus.coef_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s latency: valid=%b busy=%b one cycle after capture, required 0/1",
               name, bus.coef_valid, bus.busy);
    end
    @(negedge clk);
    cycles = 0;
    stall  = 0;
    while (sb.size() > 0 && cycles < 3000) begin
      if (cycles == 0) begin
        n_vec++;
        if (bus.coef_valid !== 1'b1) begin
          n_err++;
          $display("FAIL %s first_valid: valid=%b, required 1", name, bus.coef_valid);
        end
      end
      if (bus.coef_valid === 1'b1) begin
        rdy = !(stall_idx >= 0 && int'(bus.coef_idx) == stall_idx && stall < 5);
        if (!rdy) stall++;
        bus.coef_ready = rdy;
        n_vec++;
        if (bus.coef !== sb[0].coef || bus.coef_idx !== sb[0].idx) begin
          n_err++;
          $display("FAIL %s coef: got idx=%0d coef=%0d, required idx=%0d coef=%0d",
                   name, bus.coef_idx, bus.coef, sb[0].idx, sb[0].coef);
        end
        if (exp0 >= 0 && sb[0].idx == 8'd0) begin
          n_vec++;
          if (int'(bus.coef) != exp0) begin
            n_err++;
            $display("FAIL %s coef0: got %0d, required %0d", name, bus.coef, exp0);
          end
        end
        if (rdy) void'(sb.pop_front());
      end
      bus.start = (poke_idx >= 0 && bus.coef_valid === 1'b1 &&
                   int'(bus.coef_idx) == poke_idx);
      if (bus.start) begin
        bus.Z     = ~z;
        bus.n_num = 2'd2;
      end
      cycles++;
      @(negedge clk);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s timeout: %0d coefficients outstanding, required 0", name, sb.size());
      sb.delete();
    end
    n_vec++;
    if (bus.done !== 1'b1 || bus.coef_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s done: done=%b valid=%b busy=%b, required 1/0/0",
               name, bus.done, bus.coef_valid, bus.busy);
    end
    if (poke_done) begin
      bus.Z     = z;
      bus.n_num = 2'd1;
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_pulse: done=%b busy=%b after pulse, required 0/0",
               name, bus.done, bus.busy);
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.coef_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle: busy=%b valid=%b, required 0/0", name, bus.busy, bus.coef_valid);
    end
  endtask

  task automatic test_bad_nnum();
    kick(rand_z(), 2'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b0 || bus.coef_valid !== 1'b0 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL bad_nnum: busy=%b valid=%b done=%b, required 0/0/0",
                 bus.busy, bus.coef_valid, bus.done);
      end
    end
    kick(rand_z(), 2'd0);
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL nnum0: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_abort();
    logic [0:1535] z;
    int cnt;
    z = rand_z();
    bus.coef_ready = 1'b1;
    kick(z, 2'd1);
    @(negedge clk);
    cnt = 0;
    while (!(bus.coef_valid === 1'b1 && bus.coef_idx == 8'd100) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (cnt >= 400 || bus.coef !== model_coef(z, 3, 100)) begin
      n_err++;
      $display("FAIL abort_reach: idx=%0d coef=%0d, required idx=100 coef=%0d",
               bus.coef_idx, bus.coef, model_coef(z, 3, 100));
    end
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (bus.coef_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.coef !== 12'd0 || bus.coef_idx !== 8'd0) begin
      n_err++;
      $display("FAIL abort: valid=%b busy=%b done=%b coef=%0d idx=%0d, required all 0",
               bus.coef_valid, bus.busy, bus.done, bus.coef, bus.coef_idx);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_after: done=%b busy=%b, required 0/0", bus.done, bus.busy);
      end
    end
  endtask

  initial begin
    logic [0:1535] z;
    rst            = 1'b0;
    bus.Z          = '0;
    bus.start      = 1'b0;
    bus.n_num      = 2'd0;
    bus.coef_ready = 1'b1;

    test_reset();

    // All-zero block, eta=2.
    test_stream("zero_eta2", '0, 2'd2, 0, -1, -1, 1'b0);

    // Pattern giving +3 then -3, eta=3.
    z = '0;
    z[0:5]  = 6'b111000;
    z[6:11] = 6'b000111;
    test_stream("pattern_eta3", z, 2'd1, 3, -1, -1, 1'b0);

    // eta=2 with ones beyond the first group.
    z = '1;
    z[0:3] = 4'b1001;
    test_stream("ones_1001", z, 2'd2, 0, -1, -1, 1'b0);
    z[0:3] = 4'b0011;
    test_stream("ones_0011", z, 2'd2, 3327, -1, -1, 1'b0);

    // Backpressure at idx 10, random data, and a start during the done cycle.
    test_stream("backpressure", rand_z(), 2'd1, -1, 10, -1, 1'b1);

    test_bad_nnum();

    // Start pulsed mid-stream must not disturb the capture.
    test_stream("start_busy", rand_z(), 2'd1, -1, -1, 40, 1'b0);

    test_abort();
    test_stream("after_abort", rand_z(), 2'd2, -1, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
